pkt_rx_fsm: RTL and testbench
=============================

# pkt_rx_fsm

Frame receiver for the push-A / push-B / CRC transfer sequence. It accepts a three-beat frame on a valid/ready stream: word A, word B, then a CRC word. It checks the CRC-8 computed over A and B and presents the captured frame with a pass/fail flag on an output valid/ready port. It sits at the sink end of the link, opposite the state machine that pushes A, B and the CRC.

## Interface
- `DATA_W`, default 8: width of each frame word; must be ≥ 8.
- `CNT_W`, default 16: width of the error counter (used only with `PKT_RX_ERR_CNT_EN`).

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `in_valid`  in  1  an input beat is offered.
- `in_ready`  out  1  the block can accept a beat.
- `in_sop`  in  1  the current beat is word A of a new frame.
- `in_data`  in  DATA_W  beat payload.
- `out_valid`  out  1  a completed frame is presented.
- `out_ready`  in  1  downstream accepts the frame.
- `out_a`, `out_b`  out  DATA_W  captured words A and B.
- `out_crc_ok`  out  1  the received CRC matched the computed CRC.
- `err_cnt`  out  CNT_W  error count; present only with `PKT_RX_ERR_CNT_EN`.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge.
- States:
  - `IDLE` (waiting for A)
  - `GOT_A` (waiting for B)
  - `GOT_B` (waiting for CRC)
  - `DONE` (frame presented)
- Transitions:
  - `IDLE`: a beat with `in_sop` = 1 → capture A, seed the CRC → `GOT_A`. A beat with `in_sop` = 0 is accepted and dropped; no error is counted.
  - `GOT_A`: beat with `in_sop` = 0 → capture B, update the CRC → `GOT_B`.
  - `GOT_B`: beat with `in_sop` = 0 → compare `in_data[7:0]` with the CRC accumulator, register `out_crc_ok` → `DONE`.
  - `DONE`: `out_valid` = 1; on `out_ready` → `IDLE`.
- Resync: a beat with `in_sop` = 1 accepted in `GOT_A` or `GOT_B` aborts the partial frame and restarts with that beat as A → `GOT_A`.
- The out-of-range state encoding recovers to `IDLE`.
- `in_ready` = (state != `DONE`). No new beat is accepted while a frame is presented.
- CRC arithmetic:
  - CRC-8, polynomial 0x07, initial value 0x00, no reflection, no final XOR.
  - Processed MSB-first over all DATA_W bits of A, then B.
  - The CRC word's bits above bit 7 are ignored.
- `out_a`, `out_b`, `out_crc_ok` hold stable while `out_valid` = 1.

## Timing
- Reset (`rstn` = 0 at a rising edge), regardless of state or mid-frame:
  - state `IDLE`
  - `in_ready` = 1 on the following cycle
  - `out_valid` = 0
  - `out_a` = `out_b` = 0, `out_crc_ok` = 0
  - CRC accumulator = 0, `err_cnt` = 0
- Latency: CRC beat accepted at edge N → `out_valid` = 1 after edge N.
- Throughput: one frame per 4 cycles minimum (3 beats + 1 `DONE` cycle with `out_ready` = 1). This leaves one input bubble per frame.
- `out_ready` = 0 in `DONE` holds the frame indefinitely; `in_ready` stays 0 for the whole stall.
- A stalled `in_valid` in any receive state holds state and accumulator unchanged.

## Configuration
- `PKT_RX_ERR_CNT_EN` defined:
  - `err_cnt` port and register exist.
  - Increment on entry to `DONE` with `out_crc_ok` = 0.
  - Increment on every sop-abort.
  - Both events can never coincide.
  - The counter saturates at all-ones.
- Not defined: no port, no register; behaviour is otherwise identical.

## Structure
- Shared package `pkt_pkg`:
  - state enum `pkt_rx_state_t` (2-bit)
  - `CRC8_POLY` = 8'h07
  - `CRC8_INIT` = 8'h00
- Sub-module `crc8_word`: combinational, parameter DATA_W; inputs current CRC and data word, output next CRC. One instance is shared by the A and B updates.

## Test plan
- Good frame, no stalls: beats 0x01 (sop), 0x02, 0x1B → `out_valid` one cycle after the third beat with `out_a` = 0x01, `out_b` = 0x02, `out_crc_ok` = 1; `err_cnt` stays 0.
- Bad CRC: 0x01 (sop), 0x02, 0x1C → `out_crc_ok` = 0; `err_cnt` = 1.
- Backpressure: good frame with `out_ready` = 0 for 5 cycles → `out_valid` and outputs hold, `in_ready` = 0 throughout; frame released on the first cycle with `out_ready` = 1, then `in_ready` = 1.
- Resync: 0xAA (sop), then 0x01 (sop), 0x02, 0x1B → single `out_valid` with A = 0x01, `out_crc_ok` = 1; `err_cnt` = 1.
- Reset mid-frame: 0x01 (sop), 0x02, then `rstn` = 0 for one edge, then a full good frame → only the second frame is output; all outputs 0 after reset.
- Saturation (CNT_W = 2 override): 5 bad frames → `err_cnt` = 3.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types and constants for the pkt_rx_fsm frame receiver.
//   pkt_rx_state_t : 2-bit receive state encoding
//   CRC8_POLY/INIT : CRC-8 parameters (poly 0x07, init 0x00, no reflect/xorout)
package pkt_pkg;

  localparam int unsigned CRC_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    GOT_B = 2'd2,
    DONE  = 2'd3
  } pkt_rx_state_t;

  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/pkt_rx_fsm_if.sv
// Stream bundle between a frame source and the pkt_rx_fsm receiver.
//   in_*  : beat stream into the receiver (valid/ready, sop marks word A)
//   out_* : completed frame out of the receiver (valid/ready)
//   master: source/sink side (drives in_*, out_ready)
//   slave : receiver side (drives in_ready and the out_* payload)
interface pkt_rx_fsm_if #(
  parameter int unsigned DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic              in_sop;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_crc_ok;

  modport master (
    output in_valid, in_sop, in_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_crc_ok
  );

  modport slave (
    input  in_valid, in_sop, in_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_crc_ok
  );

endinterface

// File: rtl/pkt_rx_fsm_crc8_word.sv
// crc8_word: combinational CRC-8 update over one DATA_W-bit word, MSB first.
//   crc_in    : current accumulator
//   data      : word to fold in
//   crc_out_c : accumulator after the word
module crc8_word
  import pkt_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out_c
);

  // Bit-serial LFSR unrolled across the word.
  always_comb begin
    logic [CRC_W-1:0] c;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (c[CRC_W-1] ^ data[i]) begin
        c = {c[CRC_W-2:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[CRC_W-2:0], 1'b0};
      end
    end
    crc_out_c = c;
  end

endmodule

// File: rtl/pkt_rx_fsm.sv
// pkt_rx_fsm: receives A / B / CRC beats, checks CRC-8 over A and B, and
// presents the frame with a pass/fail flag until downstream accepts it.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : pkt_rx_fsm_if.slave (input beat stream + output frame port)
//   err_cnt   : saturating error counter, only when PKT_RX_ERR_CNT_EN is defined
// DATA_W must be at least 8; CRC word bits above bit 7 are ignored.
module pkt_rx_fsm
  import pkt_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  pkt_rx_fsm_if.slave      bus
`ifdef PKT_RX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  pkt_rx_state_t     state_q;
  pkt_rx_state_t     state_nxt_c;
  logic              accept_c;
  logic              cap_a_c;
  logic              cap_b_c;
  logic              crc_upd_c;
  logic              chk_crc_c;
  logic [CRC_W-1:0]  crc_q;
  logic [CRC_W-1:0]  crc_seed_c;
  logic [CRC_W-1:0]  crc_nxt_c;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              ok_q;

  assign bus.in_ready = (state_q != DONE);
  assign accept_c     = bus.in_valid && bus.in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt_c;
    end
  end

  // Next-state logic; an sop beat mid-frame restarts the frame at GOT_A.
  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      IDLE:    if (accept_c && bus.in_sop) state_nxt_c = GOT_A;
      GOT_A:   if (accept_c) state_nxt_c = bus.in_sop ? GOT_A : GOT_B;
      GOT_B:   if (accept_c) state_nxt_c = bus.in_sop ? GOT_A : DONE;
      DONE:    if (bus.out_ready) state_nxt_c = IDLE;
      default: state_nxt_c = IDLE;
    endcase
  end

  // Datapath controls decoded from state and the accepted beat.
  always_comb begin
    cap_a_c   = 1'b0;
    cap_b_c   = 1'b0;
    crc_upd_c = 1'b0;
    chk_crc_c = 1'b0;
    if (accept_c) begin
      case (state_q)
        IDLE: begin
          cap_a_c   = bus.in_sop;
          crc_upd_c = bus.in_sop;
        end
        GOT_A: begin
          cap_a_c   = bus.in_sop;
          cap_b_c   = !bus.in_sop;
          crc_upd_c = 1'b1;
        end
        GOT_B: begin
          cap_a_c   = bus.in_sop;
          crc_upd_c = bus.in_sop;
          chk_crc_c = !bus.in_sop;
        end
        default: ;
      endcase
    end
  end

  // One CRC engine: seeded from INIT on word A, chained from the accumulator on B.
  assign crc_seed_c = bus.in_sop ? CRC8_INIT : crc_q;

  crc8_word #(
    .DATA_W(DATA_W)
  ) u_crc (
    .crc_in   (crc_seed_c),
    .data     (bus.in_data),
    .crc_out_c(crc_nxt_c)
  );

  // Frame capture registers; untouched while DONE since nothing is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_q   <= '0;
      b_q   <= '0;
      crc_q <= CRC8_INIT;
      ok_q  <= 1'b0;
    end else begin
      if (cap_a_c)   a_q   <= bus.in_data;
      if (cap_b_c)   b_q   <= bus.in_data;
      if (crc_upd_c) crc_q <= crc_nxt_c;
      if (chk_crc_c) ok_q  <= (bus.in_data[CRC_W-1:0] == crc_q);
    end
  end

  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_a      = a_q;
  assign bus.out_b      = b_q;
  assign bus.out_crc_ok = ok_q;

`ifdef PKT_RX_ERR_CNT_EN
  logic err_evt_c;

  // A CRC miss and an sop-abort are mutually exclusive beats.
  assign err_evt_c = (chk_crc_c && (bus.in_data[CRC_W-1:0] != crc_q)) ||
                     (accept_c && bus.in_sop && (state_q == GOT_A || state_q == GOT_B));

  // Saturating error counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (err_evt_c && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_c;
  assign unused_cnt_c = '0;
`endif

endmodule

// File: tb/tb_pkt_rx_fsm.sv
// Self-checking bench for pkt_rx_fsm: directed frames plus a short random run,
// with a frame scoreboard and a bench-side model of the error counter.
module tb_pkt_rx_fsm;
  import pkt_pkg::*;

  localparam int unsigned DW = 8;
`ifdef PKT_RX_ERR_CNT_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 16;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ok;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;
  exp_t sb[$];

  pkt_rx_fsm_if #(.DATA_W(DW)) bus ();

`ifdef PKT_RX_ERR_CNT_EN
  logic [CW-1:0] err_cnt;
`endif

  pkt_rx_fsm #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
`ifdef PKT_RX_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC by long division of {a, b, 8'h00} by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] a, input logic [7:0] b);
    logic [23:0] r;
    r = {a, b, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic int sat_inc(input int v);
    int max_v;
    max_v = (1 << CW) - 1;
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  task automatic chk_err(input string tag);
`ifdef PKT_RX_ERR_CNT_EN
    chk(tag, 32'(err_cnt), 32'(exp_err));
`endif
  endtask

  // Offer one beat at the falling edge; it is accepted on the next rising edge.
  task automatic beat(input logic [7:0] d, input logic sop);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] crc,
                       input int gap);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.ok = (crc == crc_ref(a, b));
    sb.push_back(e);
    if (!e.ok) exp_err = sat_inc(exp_err);
    beat(a, 1'b1);
    repeat (gap) @(posedge clk);
    beat(b, 1'b0);
    repeat (gap) @(posedge clk);
    beat(crc, 1'b0);
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    chk("latency_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  // Frame monitor: every output handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_a", 32'(bus.out_a), 32'(e.a));
        chk("out_b", 32'(bus.out_b), 32'(e.b));
        chk("out_crc_ok", 32'(bus.out_crc_ok), 32'(e.ok));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rc;

    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_a", 32'(bus.out_a), 32'd0);
    chk("rst_out_b", 32'(bus.out_b), 32'd0);
    chk("rst_crc_ok", 32'(bus.out_crc_ok), 32'd0);
    chk_err("rst_err_cnt");

    // Good frame, then bad CRC.
    frame(8'h01, 8'h02, 8'h1B, 0);
    drain();
    chk_err("good_err_cnt");
    frame(8'h01, 8'h02, 8'h1C, 0);
    drain();
    chk_err("bad_err_cnt");

    // Backpressure: frame held while out_ready is low.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    frame(8'h33, 8'h44, crc_ref(8'h33, 8'h44), 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_a", 32'(bus.out_a), 32'h33);
      chk("stall_out_b", 32'(bus.out_b), 32'h44);
      chk("stall_crc_ok", 32'(bus.out_crc_ok), 32'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    // Input stalls between beats must not disturb the accumulator.
    frame(8'h01, 8'h02, 8'h1B, 3);
    drain();

    // Resync from GOT_A, then from GOT_B.
    sb.push_back('{a: 8'h01, b: 8'h02, ok: 1'b1});
    exp_err = sat_inc(exp_err);
    beat(8'hAA, 1'b1);
    beat(8'h01, 1'b1);
    beat(8'h02, 1'b0);
    beat(8'h1B, 1'b0);
    drain();
    chk_err("resync_a_err_cnt");
    sb.push_back('{a: 8'h5C, b: 8'hE3, ok: 1'b1});
    exp_err = sat_inc(exp_err);
    beat(8'hCC, 1'b1);
    beat(8'hDD, 1'b0);
    beat(8'h5C, 1'b1);
    beat(8'hE3, 1'b0);
    beat(crc_ref(8'h5C, 8'hE3), 1'b0);
    drain();
    chk_err("resync_b_err_cnt");

    // Non-sop beat in IDLE is dropped silently.
    beat(8'h55, 1'b0);
    frame(8'h10, 8'h20, crc_ref(8'h10, 8'h20), 0);
    drain();
    chk_err("drop_err_cnt");

    // Reset mid-frame clears everything; only the following frame appears.
    beat(8'h01, 1'b1);
    beat(8'h02, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_err = 0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_a", 32'(bus.out_a), 32'd0);
    chk("midrst_out_b", 32'(bus.out_b), 32'd0);
    chk("midrst_crc_ok", 32'(bus.out_crc_ok), 32'd0);
    chk_err("midrst_err_cnt");
    frame(8'h01, 8'h02, 8'h1B, 0);
    drain();

    // Random frames, some with a corrupted CRC and random inter-beat gaps.
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = crc_ref(ra, rb) ^ (($urandom_range(0, 1) == 1) ? 8'h5A : 8'h00);
      frame(ra, rb, rc, $urandom_range(0, 2));
      drain();
      chk_err("rand_err_cnt");
    end

    // Saturation: five bad frames after a reset.
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_err = 0;
    for (int k = 0; k < 5; k++) begin
      frame(8'h01, 8'h02, 8'h1C, 0);
      drain();
    end
    chk_err("sat_err_cnt");
`ifdef PKT_RX_ERR_CNT_EN
    chk("sat_err_cnt_value", 32'(err_cnt), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
